// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, followed by a sign fix-up cycle. One op in flight at a time.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2:0]        func3_q, func3_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_signed, b_signed, sa, sb;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [XLEN-1:0]   div_rem;
  logic              div_qbit;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v, input logic en);
    return en ? (~v + XLEN'(1)) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2w(input logic [2*XLEN-1:0] v, input logic en);
    return en ? (~v + (2*XLEN)'(1)) : v;
  endfunction

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

  always_comb begin
    a_signed  = !(func3 inside {3'b011, 3'b101, 3'b111});
    b_signed  = (func3 inside {3'b000, 3'b001, 3'b100, 3'b110});
    sa        = a_signed & rs1[XLEN-1];
    sb        = b_signed & rs2[XLEN-1];
    mag_a     = neg_w(rs1, sa);
    mag_b     = neg_w(rs2, sb);

    // Multiply: add multiplicand into the upper half, then shift the whole accumulator right.
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // Divide: remainder lives in the upper half, dividend/quotient in the lower half.
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_qbit  = !div_diff[XLEN];
    div_rem   = div_qbit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];

    prod_fix  = neg_2w(acc_q, sa_q ^ sb_q);
    quo_fix   = neg_w(acc_q[XLEN-1:0], sa_q ^ sb_q);
    rem_fix   = neg_w(acc_q[2*XLEN-1:XLEN], sa_q);

    state_d  = state_q;
    count_d  = count_q;
    func3_d  = func3_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;

    if (kill) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            func3_d = func3;
            sa_d    = sa;
            sb_d    = sb;
            count_d = '0;
            opnd_d  = func3[2] ? mag_b : mag_a;
            acc_d   = {{XLEN{1'b0}}, (func3[2] ? mag_a : mag_b)};
            if (func3[2] && (rs2 == '0)) begin
              state_d  = DONE;
              result_d = func3[1] ? rs1 : '1;
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          if (func3_q[2]) acc_d = {div_rem, acc_q[XLEN-2:0], div_qbit};
          else            acc_d = {mul_sum, acc_q[XLEN-1:1]};
          count_d = count_q + CW'(1);
          if (count_q == CW'(XLEN-1)) state_d = FIX;
        end
        FIX: begin
          state_d = DONE;
          case (func3_q)
            3'b000:                 result_d = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result_d = quo_fix;
            default:                result_d = rem_fix;
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      func3_q  <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      func3_q  <= func3_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: fixed vector table, hand-built kill/reset/start-while-busy
// sequences, and randomized ops checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  func3 = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .func3(func3),
    .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic signed [31:0] sa, sb, sq;
    logic [31:0]        r;
    sa = a;
    sb = b;
    up = {32'b0, a} * {32'b0, b};
    r  = '0;
    case (f)
      3'd0: r = up[31:0];
      3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = sp[63:32]; end
      3'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); r = sp[63:32]; end
      3'd3: r = up[63:32];
      3'd4: begin
        if (b == 0) r = '1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin sq = sa / sb; r = sq; end
      end
      3'd5: r = (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
        else begin sq = sa % sb; r = sq; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name);
    int cyc;
    bit seen, busy_ok;
    int exp_lat;
    exp_lat = (f[2] && b == 0) ? 1 : XLEN + 2;
    @(negedge clk);
    func3 = f; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; func3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
    cyc = 0; seen = 0; busy_ok = 1;
    while (!seen && cyc < XLEN + 8) begin
      @(negedge clk);
      cyc++;
      if (!busy) busy_ok = 0;
      if (done) seen = 1;
    end
    chk({name, " latency"}, 32'(cyc), 32'(exp_lat));
    chk({name, " busy"}, 32'(busy_ok), 32'd1);
    chk({name, " result"}, result, exp);
    @(negedge clk);
    chk({name, " done_after"}, 32'(done), 32'd0);
    chk({name, " busy_after"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int cyc;
    bit seen, no_done;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    tbl[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    tbl[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
    tbl[2]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[3]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    tbl[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    tbl[6]  = '{3'b101, 32'd100,        32'd7,         32'd14};
    tbl[7]  = '{3'b111, 32'd100,        32'd7,         32'd2};
    tbl[8]  = '{3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF};
    tbl[9]  = '{3'b110, 32'd5,          32'd0,         32'd5};
    tbl[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    tbl[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0};
    tbl[12] = '{3'b000, 32'h8000_0000,  32'h8000_0000, 32'd0};

    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++)
      run_op(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("vec%0d", i));

    // Kill at CALC count==10: result keeps the previous value, no done pulse.
    run_op(3'b000, 32'd3, 32'd5, 32'd15, "pre_kill");
    @(negedge clk);
    func3 = 3'b011; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    chk("kill busy", 32'(busy), 32'd0);
    no_done = 1;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) no_done = 0;
    end
    chk("kill no_done", 32'(no_done), 32'd1);
    chk("kill result", result, 32'd15);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "after_kill");

    // kill together with start in IDLE: nothing is accepted.
    @(negedge clk);
    func3 = 3'b000; rs1 = 32'd2; rs2 = 32'd3; start = 1'b1; kill = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; kill = 1'b0;
    @(negedge clk);
    chk("kill_start busy", 32'(busy), 32'd0);
    chk("kill_start result", result, 32'hFFFF_FFFE);

    // start pulsed while busy is ignored.
    @(negedge clk);
    func3 = 3'b000; rs1 = 32'd6; rs2 = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; seen = 0;
    while (!seen && cyc < XLEN + 8) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) begin func3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1; end
      if (cyc == 6) start = 1'b0;
      if (done) seen = 1;
    end
    start = 1'b0;
    chk("busy_start latency", 32'(cyc), 32'(XLEN + 2));
    chk("busy_start result", result, 32'd42);
    @(negedge clk);
    chk("busy_start idle", 32'(busy), 32'd0);

    // Reset mid-CALC clears everything immediately.
    @(negedge clk);
    func3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid busy", 32'(busy), 32'd0);
    chk("rst_mid done", 32'(done), 32'd0);
    chk("rst_mid result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b111, 32'd100, 32'd7, 32'd2, "after_reset");

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom);
      ra = pick_operand();
      rb = pick_operand();
      run_op(rf, ra, rb, model(rf, ra, rb), $sformatf("rand%0d f%0d %h %h", i, rf, ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
